// File: rtl/retire_trace_fifo_pkg.sv
// rtl/retire_trace_fifo_pkg.sv - retire-trace record layout and shared sizing
package retire_trace_fifo_pkg;
   localparam int CYCLE_W       = 32;
   localparam int PC_W          = 32;
   localparam int INSTR_W       = 32;
   localparam int WADDR_W       = 5;
   localparam int WDATA_W       = 32;
   localparam int REC_W         = CYCLE_W + PC_W + INSTR_W + 1 + WADDR_W + WDATA_W;
   localparam int DEFAULT_DEPTH = 16;

   // Field order fixes the bit offsets: cycle in the MSBs, wdata in the LSBs.
   typedef struct packed {
      logic [CYCLE_W-1:0] cycle;
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic               we;
      logic [WADDR_W-1:0] waddr;
      logic [WDATA_W-1:0] wdata;
   } trace_rec_t;
endpackage

// File: rtl/retire_trace_fifo_if.sv
// rtl/retire_trace_fifo_if.sv - commit-side capture inputs, record read port and status
interface retire_trace_fifo_if import retire_trace_fifo_pkg::*; #(
   parameter int DEPTH  = DEFAULT_DEPTH,
   parameter int DROP_W = 16
) ();
   logic                   trace_en_i;
   logic [PC_W-1:0]        pc_i;
   logic [INSTR_W-1:0]     instr_i;
   logic                   rf_we_i;
   logic [WADDR_W-1:0]     rf_waddr_i;
   logic [WDATA_W-1:0]     rf_wdata_i;
   logic                   rec_valid_o;
   logic                   rec_ready_i;
   logic [CYCLE_W-1:0]     rec_cycle_o;
   logic [PC_W-1:0]        rec_pc_o;
   logic [INSTR_W-1:0]     rec_instr_o;
   logic                   rec_we_o;
   logic [WADDR_W-1:0]     rec_waddr_o;
   logic [WDATA_W-1:0]     rec_wdata_o;
   logic [$clog2(DEPTH):0] count_o;
   logic                   full_o;
   logic [DROP_W-1:0]      drop_cnt_o;

   modport master (
      output trace_en_i, pc_i, instr_i, rf_we_i, rf_waddr_i, rf_wdata_i, rec_ready_i,
      input  rec_valid_o, rec_cycle_o, rec_pc_o, rec_instr_o, rec_we_o, rec_waddr_o,
             rec_wdata_o, count_o, full_o, drop_cnt_o
   );

   modport slave (
      input  trace_en_i, pc_i, instr_i, rf_we_i, rf_waddr_i, rf_wdata_i, rec_ready_i,
      output rec_valid_o, rec_cycle_o, rec_pc_o, rec_instr_o, rec_we_o, rec_waddr_o,
             rec_wdata_o, count_o, full_o, drop_cnt_o
   );
endinterface

// File: rtl/retire_trace_fifo_sync_fifo.sv
// rtl/retire_trace_fifo_sync_fifo.sv - first-word-fall-through FIFO with wrap-bit pointers
module retire_trace_fifo_sync_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 16,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          push,
   input  logic          pop,
   input  logic [W-1:0]  wdata,
   output logic [W-1:0]  rdata,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty
);
   logic [W-1:0] mem [DEPTH];
   logic [AW:0]  wr_ptr;
   logic [AW:0]  rd_ptr;
   logic         do_push;
   logic         do_pop;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign do_pop  = pop && !empty;
   // A pop in the same edge frees the slot, so a push into a full FIFO still lands.
   assign do_push = push && (!full || do_pop);
   assign count   = wr_ptr - rd_ptr;
   assign rdata   = empty ? '0 : mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
         if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= wdata;
   end
endmodule

// File: rtl/retire_trace_fifo.sv
// rtl/retire_trace_fifo.sv - tags per-cycle commit info with a cycle count and buffers it
module retire_trace_fifo import retire_trace_fifo_pkg::*; #(
   parameter int DEPTH     = DEFAULT_DEPTH,
   parameter bit FILTER_WB = 1'b0,
   parameter int DROP_W    = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   retire_trace_fifo_if.slave   tr
);
   localparam int AW = $clog2(DEPTH);

   logic [CYCLE_W-1:0] cycle_q;
   logic [DROP_W-1:0]  drop_q;
   trace_rec_t         wr_rec;
   trace_rec_t         rd_rec;
   logic               push;
   logic               pop;
   logic               full;
   logic               empty;
   logic [AW:0]        count;

   assign push   = tr.trace_en_i && (!FILTER_WB || tr.rf_we_i);
   assign pop    = !empty && tr.rec_ready_i;
   assign wr_rec = '{cycle: cycle_q, pc: tr.pc_i, instr: tr.instr_i, we: tr.rf_we_i,
                     waddr: tr.rf_waddr_i, wdata: tr.rf_wdata_i};

   retire_trace_fifo_sync_fifo #(.W(REC_W), .DEPTH(DEPTH)) u_fifo (
      .clk    (clk_i),
      .resetn (rst_i),
      .push   (push),
      .pop    (pop),
      .wdata  (wr_rec),
      .rdata  (rd_rec),
      .count  (count),
      .full   (full),
      .empty  (empty)
   );

   // Cycle count runs regardless of capture enable so tags measure real time.
   always_ff @(posedge clk_i) begin
      if (!rst_i) begin
         cycle_q <= '0;
         drop_q  <= '0;
      end else begin
         cycle_q <= cycle_q + CYCLE_W'(1);
         if (push && full && !pop && (drop_q != '1)) drop_q <= drop_q + DROP_W'(1);
      end
   end

   assign tr.rec_valid_o = !empty;
   assign tr.rec_cycle_o = rd_rec.cycle;
   assign tr.rec_pc_o    = rd_rec.pc;
   assign tr.rec_instr_o = rd_rec.instr;
   assign tr.rec_we_o    = rd_rec.we;
   assign tr.rec_waddr_o = rd_rec.waddr;
   assign tr.rec_wdata_o = rd_rec.wdata;
   assign tr.count_o     = count;
   assign tr.full_o      = full;
   assign tr.drop_cnt_o  = drop_q;
endmodule

// File: tb/tb_retire_trace_fifo.sv
// tb/tb_retire_trace_fifo.sv - scoreboard bench for unfiltered and write-back-filtered instances
module tb_retire_trace_fifo;
   import retire_trace_fifo_pkg::*;

   localparam int DEPTH  = 16;
   localparam int DROP_W = 16;

   logic clk_i = 1'b0;
   logic rst_i = 1'b0;
   always #5 clk_i = ~clk_i;

   retire_trace_fifo_if #(.DEPTH(DEPTH), .DROP_W(DROP_W)) bus0 ();
   retire_trace_fifo_if #(.DEPTH(DEPTH), .DROP_W(DROP_W)) bus1 ();

   retire_trace_fifo #(.DEPTH(DEPTH), .FILTER_WB(1'b0), .DROP_W(DROP_W)) dut0 (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .tr    (bus0)
   );

   retire_trace_fifo #(.DEPTH(DEPTH), .FILTER_WB(1'b1), .DROP_W(DROP_W)) dut1 (
      .clk_i (clk_i),
      .rst_i (rst_i),
      .tr    (bus1)
   );

   int          n_vec = 0;
   int          n_err = 0;
   bit          mon_on = 1'b0;
   trace_rec_t  exp0[$];
   trace_rec_t  exp1[$];
   int          occ0 = 0;
   int          occ1 = 0;
   logic [15:0] drop0 = '0;
   logic [15:0] drop1 = '0;
   logic [31:0] mcyc = '0;

   task automatic chk(input string name, input logic [REC_W-1:0] act, input logic [REC_W-1:0] expv);
      n_vec++;
      if (act !== expv) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, expv);
      end
   endtask

   // Reference model: a record is kept if there is room before the edge or the
   // sink drains one on the same edge; otherwise it is counted as lost.
   task automatic tick(input bit rst, input bit en, input bit we, input bit rdy,
                       input logic [31:0] pc, input logic [31:0] instr,
                       input logic [4:0] waddr, input logic [31:0] wdata);
      trace_rec_t rec;
      bit p0, p1, c0, c1;
      rst_i = rst;
      bus0.trace_en_i = en;  bus0.rf_we_i = we;  bus0.rec_ready_i = rdy;
      bus0.pc_i = pc;  bus0.instr_i = instr;  bus0.rf_waddr_i = waddr;  bus0.rf_wdata_i = wdata;
      bus1.trace_en_i = en;  bus1.rf_we_i = we;  bus1.rec_ready_i = rdy;
      bus1.pc_i = pc;  bus1.instr_i = instr;  bus1.rf_waddr_i = waddr;  bus1.rf_wdata_i = wdata;
      @(posedge clk_i);
      if (!rst) begin
         exp0.delete(); exp1.delete();
         occ0 = 0; occ1 = 0; drop0 = '0; drop1 = '0; mcyc = '0;
      end else begin
         rec = '{mcyc, pc, instr, we, waddr, wdata};
         p0 = rdy && (occ0 > 0);
         p1 = rdy && (occ1 > 0);
         c0 = en;
         c1 = en && we;
         if (c0 && (occ0 < DEPTH || p0)) begin exp0.push_back(rec); occ0++; end
         else if (c0 && drop0 != 16'hFFFF) drop0++;
         if (p0) occ0--;
         if (c1 && (occ1 < DEPTH || p1)) begin exp1.push_back(rec); occ1++; end
         else if (c1 && drop1 != 16'hFFFF) drop1++;
         if (p1) occ1--;
         mcyc++;
      end
      #1;
   endtask

   always @(negedge clk_i) begin
      if (mon_on) begin
         trace_rec_t a0, a1;
         a0 = '{bus0.rec_cycle_o, bus0.rec_pc_o, bus0.rec_instr_o, bus0.rec_we_o,
                bus0.rec_waddr_o, bus0.rec_wdata_o};
         a1 = '{bus1.rec_cycle_o, bus1.rec_pc_o, bus1.rec_instr_o, bus1.rec_we_o,
                bus1.rec_waddr_o, bus1.rec_wdata_o};
         chk("valid0", REC_W'(bus0.rec_valid_o), REC_W'(exp0.size() != 0));
         chk("count0", REC_W'(bus0.count_o), REC_W'(exp0.size()));
         chk("full0",  REC_W'(bus0.full_o), REC_W'(exp0.size() == DEPTH));
         chk("drop0",  REC_W'(bus0.drop_cnt_o), REC_W'(drop0));
         if (exp0.size() == 0) chk("idle_rec0", a0, '0);
         else begin
            chk("rec0", a0, exp0[0]);
            if (bus0.rec_ready_i) void'(exp0.pop_front());
         end
         chk("valid1", REC_W'(bus1.rec_valid_o), REC_W'(exp1.size() != 0));
         chk("count1", REC_W'(bus1.count_o), REC_W'(exp1.size()));
         chk("full1",  REC_W'(bus1.full_o), REC_W'(exp1.size() == DEPTH));
         chk("drop1",  REC_W'(bus1.drop_cnt_o), REC_W'(drop1));
         if (exp1.size() == 0) chk("idle_rec1", a1, '0);
         else begin
            chk("rec1", a1, exp1[0]);
            if (bus1.rec_ready_i) void'(exp1.pop_front());
         end
      end
   end

   initial begin
      repeat (2) tick(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0);
      mon_on = 1'b1;

      // three captures, inspect head, then drain
      for (int i = 0; i < 3; i++) tick(1, 1, 1, 0, 32'(i*4), 32'h00000013, 5'd1, 32'(i));
      tick(1, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0);
      repeat (4) tick(1, 0, 0, 1, 32'h0, 32'h0, 5'd0, 32'h0);

      // overflow, simultaneous push/pop while full, drain
      tick(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0);
      for (int i = 0; i < 20; i++) tick(1, 1, 1, 0, 32'(i*4), $urandom, 5'($urandom), $urandom);
      tick(1, 1, 1, 1, 32'h100, 32'hDEAD, 5'd3, 32'hBEEF);
      repeat (20) tick(1, 0, 0, 1, 32'h0, 32'h0, 5'd0, 32'h0);

      // write-back filter pattern, including destination address 16
      tick(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0);
      tick(1, 1, 1, 0, 32'h0, 32'h11, 5'd16, 32'd1);
      tick(1, 1, 0, 0, 32'h4, 32'h22, 5'd16, 32'd2);
      tick(1, 1, 1, 0, 32'h8, 32'h33, 5'd16, 32'd3);
      repeat (4) tick(1, 0, 0, 1, 32'h0, 32'h0, 5'd0, 32'h0);

      // reset with records buffered, then the next capture restarts at cycle 0
      for (int i = 0; i < 5; i++) tick(1, 1, 1, 0, $urandom, $urandom, 5'($urandom), $urandom);
      tick(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0);
      tick(1, 1, 1, 0, 32'h40, 32'h55, 5'd7, 32'h77);
      repeat (2) tick(1, 0, 0, 1, 32'h0, 32'h0, 5'd0, 32'h0);

      // randomized traffic with occasional resets
      for (int i = 0; i < 3000; i++)
         tick($urandom_range(0, 299) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
              $urandom_range(0, 2) != 0, $urandom, $urandom, 5'($urandom), $urandom);

      // drop counter saturation under sustained overflow
      tick(0, 0, 0, 0, 32'h0, 32'h0, 5'd0, 32'h0);
      for (int i = 0; i < DEPTH + 65535 + 20; i++)
         tick(1, 1, 1, 0, 32'(i), 32'h13, 5'd2, 32'(i));
      repeat (DEPTH + 2) tick(1, 0, 0, 1, 32'h0, 32'h0, 5'd0, 32'h0);

      @(negedge clk_i);
      #1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule

// File: doc/retire_trace_fifo.md
Name: retire_trace_fifo

Overview:
- Hardware retire-trace capture stage, directly downstream of the single-cycle CPU core.
- Samples the per-cycle commit information the core produces: PC, fetched instruction and register-file write-back.
- Tags each sample with a free-running cycle count and buffers the records in a FIFO.
- Records drain through a valid/ready read port to a host or trace sink, replacing per-cycle simulator printing with synthesizable capture.

Parameters:
- DEPTH, 16, number of record entries; must be a power of 2, minimum 2.
- FILTER_WB, 0, 1 = capture only cycles with rf_we_i=1; 0 = capture every enabled cycle.
- DROP_W, 16, width of the saturating dropped-record counter.

Ports:
- clk_i  in  1  system clock; all state updates on rising edge.
- rst_i  in  1  synchronous active-low reset.
- trace_en_i  in  1  capture enable.
- pc_i  in  32  byte address of the instruction executing this cycle.
- instr_i  in  32  instruction word at pc_i.
- rf_we_i  in  1  register-file write enable this cycle.
- rf_waddr_i  in  5  register-file write address.
- rf_wdata_i  in  32  register-file write data.
- rec_valid_o  out  1  head record available.
- rec_ready_i  in  1  sink accepts head record.
- rec_cycle_o  out  32  cycle tag of head record.
- rec_pc_o  out  32  PC of head record.
- rec_instr_o  out  32  instruction of head record.
- rec_we_o  out  1  write-enable of head record.
- rec_waddr_o  out  5  write address of head record.
- rec_wdata_o  out  32  write data of head record.
- count_o  out  log2(DEPTH)+1  current occupancy.
- full_o  out  1  occupancy == DEPTH.
- drop_cnt_o  out  DROP_W  records lost to overflow, saturating.

Behaviour:
- Reset: clock clk_i, synchronous active-low reset rst_i. On any rising edge with rst_i=0:
  - cycle counter, read/write pointers, count_o and drop_cnt_o cleared; full_o=0; rec_valid_o=0.
  - All rec_* data outputs read 0 while empty.
  - Reset mid-operation discards all buffered records in one edge. Storage contents need not be cleared but must never be visible.
- Cycle counter (32 bit): 0 at the first rising edge with rst_i=1 and +1 every subsequent edge, independent of trace_en_i; wraps 0xFFFFFFFF -> 0.
- Capture condition at an edge with rst_i=1: trace_en_i=1 and (FILTER_WB=0 or rf_we_i=1).
- Captured record = {cycle counter value at that edge, pc_i, instr_i, rf_we_i, rf_waddr_i, rf_wdata_i}. Writes to address 0 are recorded as-is.
- Read port is first-word-fall-through: rec_valid_o = (count_o != 0); rec_* show the head entry combinationally from registered state. A pop occurs when rec_valid_o & rec_ready_i at an edge.
- Latency: a record captured at edge N is visible on rec_* after edge N (same cycle as count_o increments).
- Push/pop arbitration, per edge:
  - Push only, not full: write at wr_ptr; count +1.
  - Pop only: rd_ptr advances; count -1.
  - Push and pop, not full: both occur; count unchanged.
  - Push and pop while full: pop frees a slot and the push is accepted; count stays DEPTH; no drop.
  - Push while full, no pop: record discarded; drop_cnt_o +1, saturating at all-ones.
  - rec_ready_i while empty: no effect.
- Pointers are log2(DEPTH)+1 bits; full/empty from MSB compare; wrap modulo DEPTH naturally.
- rec_* outputs must hold stable while rec_valid_o=1 and rec_ready_i=0.

Decomposition:
- Shared header trace_defs.vh: record field widths and bit offsets (REC_W = 134), default DEPTH.
- One natural sub-module, sync_fifo: parameterized width/depth storage with pointers, count, full/empty and FWFT read.
- retire_trace_fifo owns the cycle counter, capture qualification, record packing/unpacking and the drop counter.

Test Plan:
- Reset then trace_en_i=1 for 3 cycles, pc_i 0,4,8, rec_ready_i=0 -> count_o=3; head rec_cycle_o=0, rec_pc_o=0; pops then return cycles 1 and 2 with pc 4 and 8.
- DEPTH=16, ready=0, 20 enabled cycles -> full_o=1, count_o=16, drop_cnt_o=4; the drained records are cycles 0..15 in order.
- Full FIFO with rec_ready_i=1 and trace_en_i=1 on the same edge -> count_o stays 16, drop_cnt_o unchanged, head advances by one.
- FILTER_WB=1; rf_we_i pattern 1,0,1 with rf_waddr_i=16, wdata 1,2,3 -> exactly 2 records: wdata 1 (cycle 0) and wdata 3 (cycle 2).
- 5 records buffered, rst_i=0 for one edge -> rec_valid_o=0, count_o=0, drop_cnt_o=0; the next capture is tagged cycle 0.
- Force drop_cnt_o to 0xFFFF by sustained overflow, continue overflowing -> drop_cnt_o stays 0xFFFF.
